// File: rtl/aes_key_expansion_seq_if.sv
// Handshake and schedule bus between a key-expansion block and its consumer.
// The consumer (master) requests an expansion with start/key.
// The expander (slave) reports busy/done and presents the full schedule on w.
interface aes_key_expansion_seq_if #(
   parameter int Nk = 4,
   parameter int Nr = 10
);
   logic                    start;
   logic [32*Nk-1:0]        key;
   logic                    busy;
   logic                    done;
   logic [128*(Nr+1)-1:0]   w;

   modport master (
      output start,
      output key,
      input  busy,
      input  done,
      input  w
   );

   modport slave (
      input  start,
      input  key,
      output busy,
      output done,
      output w
   );
endinterface

// File: rtl/aes_key_expansion_seq.sv
// Iterative AES key schedule generator, one 32-bit word per clock.
// Captures the cipher key in LOAD, then derives words Nk .. 4(Nr+1)-1 in EXPAND.
// The schedule on w is stable and valid whenever done is high.
module aes_key_expansion_seq #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input logic clk,
   input logic rst_n,
   aes_key_expansion_seq_if.slave bus
);

   localparam int NW = 4 * (Nr + 1);
   localparam int IW = $clog2(NW);
   localparam int KW = $clog2(Nk);

   // Forward AES S-box, row 0 in the most-significant 128 bits.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EXPAND
   } state_t;

   state_t        state;
   logic [31:0]   words [NW];
   logic [IW-1:0] index;
   logic [KW-1:0] k;
   logic [7:0]    rcon;
   logic          busy_q;
   logic          done_q;

   logic [IW-1:0] idx_prev;
   logic [IW-1:0] idx_back;
   logic [31:0]   temp;
   logic [31:0]   new_word;

   function automatic logic [7:0] sbox_byte(input logic [7:0] b);
      return SBOX[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox_byte(x[31:24]), sbox_byte(x[23:16]),
              sbox_byte(x[15:8]),  sbox_byte(x[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] x);
      return {x[23:0], x[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   // Next schedule word: the word Nk back XORed with a transformed copy of the previous word.
   always_comb begin
      idx_prev = index - IW'(1);
      idx_back = index - IW'(Nk);
      temp     = words[idx_prev];
      if (k == '0) begin
         temp = sub_word(rot_word(words[idx_prev])) ^ {rcon, 24'h0};
      end else if (Nk == 8 && k == KW'(4)) begin
         temp = sub_word(words[idx_prev]);
      end
      new_word = words[idx_back] ^ temp;
   end

   // Control FSM and word storage; busy/done are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         index  <= '0;
         k      <= '0;
         rcon   <= 8'h01;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         for (int i = 0; i < NW; i++) begin
            words[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= LOAD;
                  busy_q <= 1'b1;
                  done_q <= 1'b0;
               end
            end
            LOAD: begin
               for (int i = 0; i < Nk; i++) begin
                  words[i] <= bus.key[32*Nk-1-32*i -: 32];
               end
               index  <= IW'(Nk);
               k      <= '0;
               rcon   <= 8'h01;
               busy_q <= 1'b1;
               done_q <= 1'b0;
               state  <= EXPAND;
            end
            EXPAND: begin
               words[index] <= new_word;
               if (k == '0) begin
                  rcon <= xtime(rcon);
               end
               if (k == KW'(Nk - 1)) begin
                  k <= '0;
               end else begin
                  k <= k + KW'(1);
               end
               if (index == IW'(NW - 1)) begin
                  index  <= '0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= IDLE;
               end else begin
                  index <= index + IW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;

   // Word i lands in round key i/4, column i%4, with column 0 most significant.
   for (genvar gi = 0; gi < NW; gi++) begin : g_wmap
      assign bus.w[(gi/4)*128 + (3-(gi%4))*32 +: 32] = words[gi];
   end

endmodule

// File: tb/tb_aes_key_expansion_seq.sv
// Directed bench for the AES key schedule generator at all three key sizes.
// Expected schedule values are the published FIPS-197 expansion vectors.
module tb_aes_key_expansion_seq;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   aes_key_expansion_seq_if #(.Nk(4), .Nr(10)) i128 ();
   aes_key_expansion_seq_if #(.Nk(6), .Nr(12)) i192 ();
   aes_key_expansion_seq_if #(.Nk(8), .Nr(14)) i256 ();

   aes_key_expansion_seq #(.Nk(4), .Nr(10)) u128 (.clk(clk), .rst_n(rst_n), .bus(i128));
   aes_key_expansion_seq #(.Nk(6), .Nr(12)) u192 (.clk(clk), .rst_n(rst_n), .bus(i192));
   aes_key_expansion_seq #(.Nk(8), .Nr(14)) u256 (.clk(clk), .rst_n(rst_n), .bus(i256));

   localparam logic [255:0] K128  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192  = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KC1   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [127:0] RK10A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RK10C = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   function automatic logic get_busy(input int sel);
      case (sel)
         0:       return i128.busy;
         1:       return i192.busy;
         default: return i256.busy;
      endcase
   endfunction

   function automatic logic get_done(input int sel);
      case (sel)
         0:       return i128.done;
         1:       return i192.done;
         default: return i256.done;
      endcase
   endfunction

   function automatic logic [1919:0] get_w(input int sel);
      case (sel)
         0:       return 1920'(i128.w);
         1:       return 1920'(i192.w);
         default: return i256.w;
      endcase
   endfunction

   function automatic logic [127:0] round_key(input int sel, input int r);
      logic [1919:0] all;
      all = get_w(sel);
      return all[r*128 +: 128];
   endfunction

   function automatic logic [31:0] word_at(input int sel, input int i);
      logic [127:0] rk;
      rk = round_key(sel, i / 4);
      return rk[(3 - (i % 4))*32 +: 32];
   endfunction

   task automatic set_key(input int sel, input logic [255:0] key_val);
      case (sel)
         0:       i128.key = key_val[255 -: 128];
         1:       i192.key = key_val[255 -: 192];
         default: i256.key = key_val;
      endcase
   endtask

   task automatic set_start(input int sel, input logic val);
      case (sel)
         0:       i128.start = val;
         1:       i192.start = val;
         default: i256.start = val;
      endcase
   endtask

   // Start one expansion and measure edges until done, counting busy cycles.
   task automatic applyStimulus(input int sel, input logic [255:0] key_val, input bit hold,
                                input logic [255:0] alt_key, output int latency, output int busy_cycles);
      @(negedge clk);
      set_key(sel, key_val);
      set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      busy_cycles = get_busy(sel) ? 1 : 0;
      checkOutput("done_low_after_start", 128'(get_done(sel)), 128'(0));
      if (!hold) set_start(sel, 1'b0);
      latency = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (hold && n == 10) set_key(sel, alt_key);
         if (get_busy(sel)) busy_cycles++;
         if (get_done(sel)) begin
            latency = n;
            break;
         end
      end
   endtask

   // Global watchdog so the bench can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int lat;
      int bcy;
      bit seen;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      i128.start = 1'b0; i128.key = '0;
      i192.start = 1'b0; i192.key = '0;
      i256.start = 1'b0; i256.key = '0;
      #12;
      checkOutput("reset_busy", 128'(i128.busy), 128'(0));
      checkOutput("reset_done", 128'(i128.done), 128'(0));
      checkOutput("reset_w", 128'(|get_w(0)), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, K128, 1'b0, '0, lat, bcy);
      checkOutput("aes128_latency", 128'(lat), 128'(41));
      checkOutput("aes128_busy_cycles", 128'(bcy), 128'(41));
      checkOutput("aes128_rk0", round_key(0, 0), K128[255 -: 128]);
      checkOutput("aes128_rk1", round_key(0, 1), 128'ha0fafe1788542cb123a339392a6c7605);
      checkOutput("aes128_rk2", round_key(0, 2), 128'hf2c295f27a96b9435935807a7359f67f);
      checkOutput("aes128_rk10", round_key(0, 10), RK10A);

      applyStimulus(1, K192, 1'b0, '0, lat, bcy);
      checkOutput("aes192_latency", 128'(lat), 128'(47));
      checkOutput("aes192_word6", 128'(word_at(1, 6)), 128'h fe0c91f7);
      checkOutput("aes192_rk12", round_key(1, 12), 128'he98ba06f448c773c8ecc720401002202);

      applyStimulus(2, K256, 1'b0, '0, lat, bcy);
      checkOutput("aes256_latency", 128'(lat), 128'(53));
      checkOutput("aes256_word8", 128'(word_at(2, 8)), 128'h9ba35411);
      checkOutput("aes256_word12", 128'(word_at(2, 12)), 128'ha8b09c1a);
      checkOutput("aes256_rk14", round_key(2, 14), 128'hfe4890d1e6188d0b046df344706c631e);

      // Asynchronous reset in the middle of an expansion.
      @(negedge clk);
      set_key(0, K128);
      set_start(0, 1'b1);
      @(posedge clk);
      #1;
      set_start(0, 1'b0);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midrun_reset_busy", 128'(i128.busy), 128'(0));
      checkOutput("midrun_reset_done", 128'(i128.done), 128'(0));
      checkOutput("midrun_reset_w", 128'(|get_w(0)), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, K128, 1'b0, '0, lat, bcy);
      checkOutput("after_reset_latency", 128'(lat), 128'(41));
      checkOutput("after_reset_rk10", round_key(0, 10), RK10A);

      // Back-to-back run with a different key.
      applyStimulus(0, KC1, 1'b0, '0, lat, bcy);
      checkOutput("b2b_latency", 128'(lat), 128'(41));
      checkOutput("b2b_rk10", round_key(0, 10), RK10C);

      // start held high throughout, key changed mid-run.
      applyStimulus(0, K128, 1'b1, KC1, lat, bcy);
      checkOutput("hold_latency", 128'(lat), 128'(41));
      checkOutput("hold_rk10", round_key(0, 10), RK10A);
      @(posedge clk);
      #1;
      checkOutput("hold_restart_done", 128'(i128.done), 128'(0));
      checkOutput("hold_restart_busy", 128'(i128.busy), 128'(1));
      set_start(0, 1'b0);
      seen = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk);
         #1;
         if (i128.done) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("hold_rerun_done", 128'(seen), 128'(1));
      checkOutput("hold_rerun_rk10", round_key(0, 10), RK10C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_key_expansion_seq.md
Name: aes_key_expansion_seq

Overview:
Iterative AES key-schedule generator. It expands a cipher key into the full schedule of (Nr+1) round keys, producing one 32-bit word per clock. Its w output feeds the inverse-cipher and cipher datapaths directly. It replaces a combinational unrolled expansion with a start/done handshake block, so the decryptor sees a stable schedule once done is high.

Parameters:
Nk, 4, key length in 32-bit words (4, 6 or 8 -> AES-128/192/256)
Nr, 10, number of rounds (10, 12 or 14; must equal Nk+6)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request expansion of key; sampled only when not busy
key  input  32*Nk  cipher key; key[32*Nk-1 -: 32] is word 0 (FIPS-197 byte order)
busy  output  1  expansion in progress
done  output  1  schedule complete and stable; level signal
w  output  128*(Nr+1)  key schedule; round key r at w[r*128 +: 128]

Behaviour:
- Word layout: word i (0 <= i < 4(Nr+1)) maps to round key r=i/4, column c=i%4. It sits at w[r*128 + (3-c)*32 +: 32], so word 4r is the most-significant word of round key r.
- Reset (rst_n low, asynchronous): busy=0, done=0, w=0, index=0, Rcon=8'h01, FSM=IDLE. Reset mid-expansion aborts; no partial result is flagged done.
- FSM states: IDLE, LOAD, EXPAND.
- IDLE:
  - start=1 -> LOAD.
  - done keeps its previous value.
- LOAD (1 cycle):
  - Capture the key into words 0..Nk-1.
  - Set index=Nk, modulo counter k=0, Rcon=8'h01.
  - Set busy=1, done=0.
  - -> EXPAND.
- EXPAND: one word per cycle, at index i.
  - temp = word i-1.
  - If k==0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}; then Rcon <= xtime(Rcon), where xtime = left shift with conditional ^8'h1b on carry-out.
  - Else if Nk==8 and k==4: temp = SubWord(temp).
  - Word i <= word i-Nk ^ temp. i increments; k wraps Nk-1 -> 0.
  - After writing word 4(Nr+1)-1 -> IDLE, with busy=0 and done=1 in the following cycle.
- Latency: start sampled at edge T -> done high at edge T+1+(4(Nr+1)-Nk).
  - AES-128: 41 cycles.
  - AES-192: 47 cycles.
  - AES-256: 53 cycles.
- SubWord uses the codebase's existing forward S-box, 4 byte lookups. RotWord = {b1,b2,b3,b0}.
- start while busy: ignored. key changes while busy: ignored, since key is sampled only in LOAD.
- start in IDLE with done=1: done drops in LOAD and the schedule is rebuilt. Consumers must treat w as valid only while done=1.
- w bits for words not yet generated keep stale values during EXPAND.
- Expansion arithmetic is bitwise XOR only; no width growth.

Test Plan:
- Reset: assert rst_n=0 mid-EXPAND -> busy=0, done=0 and w=0 immediately, without waiting for a clock edge. Release, pulse start -> full run completes normally.
- AES-128 (Nk=4, Nr=10), key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
  - busy high for 41 cycles; done at T+41.
  - w[128+:128] = a0fafe1788542cb123a339392a6c7605.
  - w[1280+:128] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> word 6 = fe0c91f7; round key 12 = e98ba06f448c773c8ecc720401002202; done at T+47.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - word 8 = 9ba35411; word 12 = a8b09c1a (exercises the k==4 SubWord path).
  - round key 14 = fe4890d1e6188d0b046df344706c631e; done at T+53.
- Handshake: hold start=1 throughout and change key mid-run -> result matches the original key. done rises once per run, and a new run begins on the cycle after returning to IDLE.
- Back-to-back: second start with a different key after done -> done=0 during the rerun, and final w matches the second key's vectors.
